// File: rtl/div_unit_pkg.sv
// Shared CPU package: divider state encoding and iteration count, also used by
// the control unit to time its divide wait state.
package div_unit_pkg;

  localparam int unsigned DIV_ITER = 32;
  localparam int unsigned CNT_W    = $clog2(DIV_ITER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } divState_t;

endpackage

// File: rtl/div_unit_if.sv
// Handshake and operand/result bundle between the control unit, the A/B
// registers and the divider.
interface div_unit_if #(
  parameter int unsigned WIDTH = 32
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start, a, b,
    input  hi, lo, busy, done, div_zero
  );

  modport slave (
    input  start, a, b,
    output hi, lo, busy, done, div_zero
  );

endinterface

// File: rtl/div_unit_step.sv
// One restoring-division iteration on unsigned magnitudes: shift {rem, quot}
// left and subtract the divisor when it fits.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quot,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remNext,
  output logic [WIDTH-1:0] quotNext
);

  logic [WIDTH:0] remSh;
  logic [WIDTH:0] trial;

  always_comb begin
    remSh = {rem, quot[WIDTH-1]};
    trial = remSh - {1'b0, divisor};
    // remSh < 2*divisor, so bit WIDTH of trial is set exactly when it borrowed
    if (!trial[WIDTH]) begin
      remNext  = trial[WIDTH-1:0];
      quotNext = {quot[WIDTH-2:0], 1'b1};
    end else begin
      remNext  = remSh[WIDTH-1:0];
      quotNext = {quot[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Sequential signed divider (MIPS div): remainder to hi, quotient to lo,
// fixed 33-edge latency from launch to done, zero-divisor flagged immediately.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic       clock,
  input  logic       reset,
  div_unit_if.slave  bus
);

  import div_unit_pkg::*;

  divState_t        state, stateNext;
  logic [WIDTH-1:0] rem, quot, divisor;
  logic [WIDTH-1:0] remNext, quotNext;
  logic [WIDTH-1:0] absA, absB;
  logic [WIDTH-1:0] hiR, loR;
  logic [CNT_W-1:0] cnt;
  logic             signQ, signR;
  logic             busyR, doneR, zeroR;
  logic             zeroDiv;

  assign absA    = bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign absB    = bus.b[WIDTH-1] ? -bus.b : bus.b;
  assign zeroDiv = (bus.b == '0);

  div_step #(.WIDTH(WIDTH)) uStep (
    .rem      (rem),
    .quot     (quot),
    .divisor  (divisor),
    .remNext  (remNext),
    .quotNext (quotNext)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (bus.start) stateNext = zeroDiv ? DONE : CALC;
      CALC:    if (cnt == CNT_W'(DIV_ITER - 1)) stateNext = FIX;
      FIX:     stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rem     <= '0;
      quot    <= '0;
      divisor <= '0;
      signQ   <= 1'b0;
      signR   <= 1'b0;
      cnt     <= '0;
      hiR     <= '0;
      loR     <= '0;
      busyR   <= 1'b0;
      doneR   <= 1'b0;
      zeroR   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (zeroDiv) begin
              doneR <= 1'b1;
              zeroR <= 1'b1;
            end else begin
              rem     <= '0;
              quot    <= absA;
              divisor <= absB;
              signQ   <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
              signR   <= bus.a[WIDTH-1];
              cnt     <= '0;
              busyR   <= 1'b1;
            end
          end
        end
        CALC: begin
          rem  <= remNext;
          quot <= quotNext;
          cnt  <= cnt + CNT_W'(1);
        end
        FIX: begin
          loR   <= signQ ? -quot : quot;
          hiR   <= signR ? -rem : rem;
          busyR <= 1'b0;
          doneR <= 1'b1;
        end
        DONE: begin
          doneR <= 1'b0;
          zeroR <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.hi       = hiR;
  assign bus.lo       = loR;
  assign bus.busy     = busyR;
  assign bus.done     = doneR;
  assign bus.div_zero = zeroR;

endmodule
